ddsm_cfg_ctrl: RTL and testbench
================================

Name: ddsm_cfg_ctrl

Overview:
Configuration sequencer for the MASH DDSM error-feedback stages. It accepts a modulator configuration through a valid/ready handshake: accumulator width, MASH order, seed and fractional word. It then drives the stage select masks (sum mask and one-hot carry select), seed and fractional data into the EFM stages. It sequences a controlled reset/flush and pipeline fill before flagging the modulator output as valid. It sits between the register/host interface and the EFM stage chain.

Parameters:
P_DATA_WIDTH, 8, datapath width of the EFM stages; only 8 is supported.
P_RST_CYCLES, 4, cycles the stage reset is held low after a configuration load (1..255).
P_PIPE_LAT, 8, carry-pipeline latency of one EFM stage in cycles (1..31).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_cfg_valid  in  1  configuration request
o_cfg_ready  out  1  configuration can be accepted
i_cfg_width  in  4  accumulator width, legal 1..8
i_cfg_order  in  2  MASH order, legal 1..3
i_cfg_seed  in  8  seed applied to stage accumulators during stage reset
i_frac_wr  in  1  fractional-word write strobe, usable in any state
i_frac  in  8  fractional input word
o_cfg_err  out  1  one-cycle pulse: illegal configuration rejected
o_sum_sel  out  8  sum mask to EFM stages
o_cout_sel  out  9  one-hot carry select to EFM stages
o_seed  out  8  active seed
o_efm_data  out  8  fractional word masked to the active width
o_stage_en  out  3  thermometer enable, one bit per MASH stage
o_mod_rst_n  out  1  active-low reset to EFM stages
o_out_valid  out  1  modulator output is valid
o_busy  out  1  high in LOAD, HOLD, FILL

Behaviour:
- Reset values (async, immediate):
  - state = IDLE, o_cfg_ready = 1, o_cfg_err = 0, o_out_valid = 0, o_busy = 0.
  - o_mod_rst_n = 0, o_sum_sel = 0, o_cout_sel = 9'h001, o_seed = 0, o_efm_data = 0, o_stage_en = 0.
  - Shadow frac register = 0; counter = 0.
- Acceptance: a configuration is accepted when i_cfg_valid & o_cfg_ready.
- o_cfg_ready = 1 only in IDLE and RUN; it is a registered function of the state.
- Illegal configuration (width 0 or width > 8, or order 0):
  - Not accepted into active registers; o_cfg_err pulses 1 on the next cycle.
  - State and all outputs are unchanged.
- States and transitions:
  - IDLE -> LOAD on a legal acceptance.
  - LOAD (1 cycle):
    - o_sum_sel = (1<<width)-1; o_cout_sel = one-hot bit[width], so width 8 sets bit 8.
    - o_seed = cfg seed; o_stage_en = thermometer of order (1 -> 3'b001, 3 -> 3'b111).
    - o_mod_rst_n = 0, o_out_valid = 0. Next state HOLD, counter loaded with P_RST_CYCLES-1.
  - HOLD: o_mod_rst_n = 0; counter decrements. When counter = 0: go to FILL, o_mod_rst_n = 1, counter = P_PIPE_LAT*order-1.
  - FILL: counter decrements. When counter = 0: go to RUN, o_out_valid = 1.
  - RUN: outputs stable. A legal acceptance -> LOAD; o_out_valid drops on the cycle after acceptance.
- Cycle budget: from an accepted cfg, o_mod_rst_n rises exactly 1+P_RST_CYCLES cycles later. o_out_valid rises a further P_PIPE_LAT*order cycles after that.
- Fractional word:
  - i_frac_wr updates the shadow register in any state.
  - o_efm_data = shadow & o_sum_sel, registered, 1-cycle latency.
  - In LOAD, o_efm_data recomputes with the new mask on the following cycle.
- Simultaneous events:
  - i_frac_wr together with cfg acceptance: both take effect; the new frac is masked with the new width.
  - i_cfg_valid during LOAD/HOLD/FILL: ignored (ready = 0), no error pulse, held request not lost if the host keeps valid asserted.
- Reset mid-operation: any state returns immediately to reset values; the previous configuration is discarded.
- o_busy = (state is LOAD, HOLD or FILL).

Test Plan:
- Reset release, no cfg for 20 cycles -> ready=1, mod_rst_n=0, out_valid=0, cout_sel=9'h001, sum_sel=0 throughout.
- Cfg width=8, order=3, seed=0x5A with defaults -> sum_sel=0xFF, cout_sel=9'h100, stage_en=3'b111, seed=0x5A. mod_rst_n rises 5 cycles after acceptance; out_valid rises 24 cycles later.
- Cfg width=5, order=1, frac=0xF3 -> sum_sel=0x1F, cout_sel=9'h020, efm_data=0x13. out_valid rises 8 cycles after mod_rst_n rises.
- Cfg width=0 and cfg order=0 each in IDLE and RUN -> one-cycle cfg_err each, state/outputs unchanged, out_valid stays at prior value.
- In RUN (width 8), new cfg width=4 with simultaneous frac_wr 0xAB -> out_valid falls next cycle, mod_rst_n low for 4 cycles; efm_data becomes 0x0B; full refill before out_valid.
- Assert i_rst_n low during FILL -> all outputs at reset values in the same cycle; after release, state is IDLE.

Source files
------------

// File: rtl/ddsm_cfg_ctrl.sv
// Configuration sequencer for the MASH DDSM error-feedback stage chain: loads stage
// masks and seed, then runs a stage reset and a pipeline fill before flagging valid output.
module ddsm_cfg_ctrl #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_RST_CYCLES = 4,
    parameter int P_PIPE_LAT   = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ready,
    input  logic [3:0]              i_cfg_width,
    input  logic [1:0]              i_cfg_order,
    input  logic [P_DATA_WIDTH-1:0] i_cfg_seed,
    input  logic                    i_frac_wr,
    input  logic [P_DATA_WIDTH-1:0] i_frac,
    output logic                    o_cfg_err,
    output logic [P_DATA_WIDTH-1:0] o_sum_sel,
    output logic [P_DATA_WIDTH:0]   o_cout_sel,
    output logic [P_DATA_WIDTH-1:0] o_seed,
    output logic [P_DATA_WIDTH-1:0] o_efm_data,
    output logic [2:0]              o_stage_en,
    output logic                    o_mod_rst_n,
    output logic                    o_out_valid,
    output logic                    o_busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;

    localparam logic [7:0] LP_HOLD_LOAD = 8'(P_RST_CYCLES - 1);
    localparam logic [7:0] LP_PIPE_LAT  = 8'(P_PIPE_LAT);

    logic [2:0]              r_state;
    logic [7:0]              r_cnt;
    logic [1:0]              r_order;
    logic                    r_cfg_ready;
    logic                    r_cfg_err;
    logic                    r_busy;
    logic                    r_mod_rst_n;
    logic                    r_out_valid;
    logic [P_DATA_WIDTH-1:0] r_frac;
    logic [P_DATA_WIDTH-1:0] r_sum_sel;
    logic [P_DATA_WIDTH:0]   r_cout_sel;
    logic [P_DATA_WIDTH-1:0] r_seed;
    logic [P_DATA_WIDTH-1:0] r_efm_data;
    logic [2:0]              r_stage_en;

    logic                    w_accept;
    logic                    w_legal;
    logic                    w_load;
    logic                    w_reject;
    logic [2:0]              w_state_nxt;
    logic [P_DATA_WIDTH:0]   w_one;
    logic [P_DATA_WIDTH:0]   w_cout_sel;
    logic [P_DATA_WIDTH-1:0] w_sum_sel;
    logic [2:0]              w_stage_en;
    logic [7:0]              w_fill_load;

    assign w_accept = i_cfg_valid & r_cfg_ready;
    assign w_legal  = (i_cfg_width != 4'd0) && (i_cfg_width <= 4'(P_DATA_WIDTH))
                      && (i_cfg_order != 2'd0);
    assign w_load   = w_accept & w_legal;
    assign w_reject = w_accept & ~w_legal;

    // Width 8 selects carry bit 8; the sum mask is that one-hot minus one, truncated.
    assign w_one       = {{P_DATA_WIDTH{1'b0}}, 1'b1};
    assign w_cout_sel  = w_one << i_cfg_width;
    assign w_sum_sel   = w_cout_sel[P_DATA_WIDTH-1:0] - w_one[P_DATA_WIDTH-1:0];
    assign w_fill_load = (LP_PIPE_LAT * {6'd0, r_order}) - 8'd1;

    always_comb begin
        w_stage_en = 3'b000;
        case (i_cfg_order)
            2'd1:    w_stage_en = 3'b001;
            2'd2:    w_stage_en = 3'b011;
            2'd3:    w_stage_en = 3'b111;
            default: w_stage_en = 3'b000;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RUN: if (w_load) w_state_nxt = S_LOAD;
            S_LOAD:        w_state_nxt = S_HOLD;
            S_HOLD:        if (r_cnt == 8'd0) w_state_nxt = S_FILL;
            S_FILL:        if (r_cnt == 8'd0) w_state_nxt = S_RUN;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_order     <= 2'd0;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_mod_rst_n <= 1'b0;
            r_out_valid <= 1'b0;
            r_frac      <= '0;
            r_sum_sel   <= '0;
            r_cout_sel  <= w_one;
            r_seed      <= '0;
            r_efm_data  <= '0;
            r_stage_en  <= 3'b000;
        end else begin
            r_state     <= w_state_nxt;
            r_cfg_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RUN);
            r_busy      <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_HOLD)
                           || (w_state_nxt == S_FILL);
            r_cfg_err   <= w_reject;
            r_efm_data  <= r_frac & r_sum_sel;
            if (i_frac_wr) begin
                r_frac <= i_frac;
            end
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (w_load) begin
                        r_sum_sel   <= w_sum_sel;
                        r_cout_sel  <= w_cout_sel;
                        r_seed      <= i_cfg_seed;
                        r_stage_en  <= w_stage_en;
                        r_order     <= i_cfg_order;
                        r_mod_rst_n <= 1'b0;
                        r_out_valid <= 1'b0;
                    end
                end
                S_LOAD: r_cnt <= LP_HOLD_LOAD;
                S_HOLD: begin
                    if (r_cnt == 8'd0) begin
                        r_mod_rst_n <= 1'b1;
                        r_cnt       <= w_fill_load;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_FILL: begin
                    if (r_cnt == 8'd0) begin
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_cnt <= 8'd0;
            endcase
        end
    end

    assign o_cfg_ready = r_cfg_ready;
    assign o_cfg_err   = r_cfg_err;
    assign o_busy      = r_busy;
    assign o_mod_rst_n = r_mod_rst_n;
    assign o_out_valid = r_out_valid;
    assign o_sum_sel   = r_sum_sel;
    assign o_cout_sel  = r_cout_sel;
    assign o_seed      = r_seed;
    assign o_efm_data  = r_efm_data;
    assign o_stage_en  = r_stage_en;

endmodule

// File: tb/tb_ddsm_cfg_ctrl.sv
// Self-checking bench for ddsm_cfg_ctrl: a cycle-arithmetic reference model is compared
// against every output each cycle, plus directed literal checks and randomized traffic.
module tb_ddsm_cfg_ctrl;

    localparam int RST_CYC  = 4;
    localparam int PIPE_LAT = 8;

    logic       clk;
    logic       rstN;
    logic       cfgValid;
    logic       cfgReady;
    logic [3:0] cfgWidth;
    logic [1:0] cfgOrder;
    logic [7:0] cfgSeed;
    logic       fracWr;
    logic [7:0] frac;
    logic       cfgErr;
    logic [7:0] sumSel;
    logic [8:0] coutSel;
    logic [7:0] seed;
    logic [7:0] efmData;
    logic [2:0] stageEn;
    logic       modRstN;
    logic       outValid;
    logic       busy;

    int nTests = 0;
    int nFail  = 0;
    bit chkEn  = 0;

    ddsm_cfg_ctrl #(
        .P_DATA_WIDTH(8),
        .P_RST_CYCLES(RST_CYC),
        .P_PIPE_LAT  (PIPE_LAT)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_cfg_valid(cfgValid),
        .o_cfg_ready(cfgReady),
        .i_cfg_width(cfgWidth),
        .i_cfg_order(cfgOrder),
        .i_cfg_seed (cfgSeed),
        .i_frac_wr  (fracWr),
        .i_frac     (frac),
        .o_cfg_err  (cfgErr),
        .o_sum_sel  (sumSel),
        .o_cout_sel (coutSel),
        .o_seed     (seed),
        .o_efm_data (efmData),
        .o_stage_en (stageEn),
        .o_mod_rst_n(modRstN),
        .o_out_valid(outValid),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remembers the last legal configuration and the cycle it was
    // accepted; every timing output is derived from the elapsed cycle count.
    int mCyc    = 0;
    int mTacc   = 0;
    int mWidth  = 0;
    int mOrder  = 0;
    int mSeed   = 0;
    int mShadow = 0;
    int mEfm    = 0;
    bit mErr    = 0;

    function automatic int maskOf(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic bit modelBusy(input int cyc);
        return (mWidth != 0) && ((cyc - mTacc) < (1 + RST_CYC + PIPE_LAT * mOrder));
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mWidth  = 0;
            mOrder  = 0;
            mSeed   = 0;
            mShadow = 0;
            mEfm    = 0;
            mErr    = 0;
        end else begin
            bit rdy;
            bit legal;
            int efmNew;
            rdy    = !modelBusy(mCyc);
            mCyc   = mCyc + 1;
            efmNew = mShadow & maskOf(mWidth);
            if (fracWr) mShadow = int'(frac);
            legal = (cfgWidth >= 4'd1) && (cfgWidth <= 4'd8) && (cfgOrder != 2'd0);
            mErr  = cfgValid && rdy && !legal;
            if (cfgValid && rdy && legal) begin
                mWidth = int'(cfgWidth);
                mOrder = int'(cfgOrder);
                mSeed  = int'(cfgSeed);
                mTacc  = mCyc;
            end
            mEfm = efmNew;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chkEn) begin
            int  d;
            int  tot;
            bit  have;
            bit  bsy;
            have = (mWidth != 0);
            d    = mCyc - mTacc;
            tot  = 1 + RST_CYC + PIPE_LAT * mOrder;
            bsy  = modelBusy(mCyc);
            checkOutput("cfg_ready", 32'(cfgReady), 32'(!bsy));
            checkOutput("busy",      32'(busy),     32'(bsy));
            checkOutput("cfg_err",   32'(cfgErr),   32'(mErr));
            checkOutput("mod_rst_n", 32'(modRstN),  32'(have && d >= 1 + RST_CYC));
            checkOutput("out_valid", 32'(outValid), 32'(have && d >= tot));
            checkOutput("sum_sel",   32'(sumSel),   32'(maskOf(mWidth)));
            checkOutput("cout_sel",  32'(coutSel),  32'(1 << mWidth));
            checkOutput("seed",      32'(seed),     32'(mSeed));
            checkOutput("stage_en",  32'(stageEn),  32'(maskOf(mOrder)));
            checkOutput("efm_data",  32'(efmData),  32'(mEfm));
        end
    end

    task automatic applyStimulus(input bit v, input int w, input int o, input int s,
                                 input bit fw, input int f);
        @(negedge clk);
        cfgValid = v;
        cfgWidth = 4'(w);
        cfgOrder = 2'(o);
        cfgSeed  = 8'(s);
        fracWr   = fw;
        frac     = 8'(f);
    endtask

    // One-cycle request; returns at the negedge right after the acceptance edge.
    task automatic applyCfg(input int w, input int o, input int s, input bit fw, input int f);
        applyStimulus(1'b1, w, o, s, fw, f);
        @(negedge clk);
        cfgValid = 1'b0;
        fracWr   = 1'b0;
    endtask

    // Counts negedges until the chosen output is high; gives up at the bound.
    task automatic waitRise(input bit pickValid, input int bound, output int k);
        k = 0;
        while (((pickValid ? outValid : modRstN) !== 1'b1) && (k < bound)) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        cfgValid = 0; cfgWidth = 0; cfgOrder = 0; cfgSeed = 0; fracWr = 0; frac = 0;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        chkEn = 1;
        rstN  = 1'b1;

        // Idle after reset, then illegal requests in IDLE.
        repeat (20) @(negedge clk);
        checkOutput("idle_ready", 32'(cfgReady), 32'd1);
        checkOutput("idle_cout",  32'(coutSel),  32'h001);
        checkOutput("idle_rstn",  32'(modRstN),  32'd0);
        applyCfg(0, 1, 8'h12, 0, 0);
        checkOutput("idle_err_w0", 32'(cfgErr), 32'd1);
        applyCfg(3, 0, 8'h12, 0, 0);
        checkOutput("idle_err_o0", 32'(cfgErr), 32'd1);
        checkOutput("idle_err_busy", 32'(busy), 32'd0);
        applyCfg(9, 2, 8'h12, 0, 0);
        checkOutput("idle_err_w9", 32'(cfgErr), 32'd1);
        @(negedge clk);
        checkOutput("err_one_shot", 32'(cfgErr), 32'd0);

        // Width 8, order 3.
        applyCfg(8, 3, 8'h5A, 0, 0);
        checkOutput("w8_sum",   32'(sumSel),  32'hFF);
        checkOutput("w8_cout",  32'(coutSel), 32'h100);
        checkOutput("w8_stage", 32'(stageEn), 32'h7);
        checkOutput("w8_seed",  32'(seed),    32'h5A);
        waitRise(1'b0, 100, k);
        checkOutput("w8_rstn_lat", 32'(k), 32'd5);
        waitRise(1'b1, 100, k);
        checkOutput("w8_valid_lat", 32'(k), 32'd24);

        // Width 5, order 1 with simultaneous frac write.
        applyCfg(5, 1, 8'h11, 1, 8'hF3);
        waitRise(1'b0, 100, k);
        checkOutput("w5_rstn_lat", 32'(k), 32'd5);
        waitRise(1'b1, 100, k);
        checkOutput("w5_valid_lat", 32'(k), 32'd8);
        checkOutput("w5_sum",  32'(sumSel),  32'h1F);
        checkOutput("w5_cout", 32'(coutSel), 32'h020);
        checkOutput("w5_efm",  32'(efmData), 32'h13);

        // Illegal requests in RUN leave everything untouched.
        applyCfg(0, 2, 8'h77, 0, 0);
        checkOutput("run_err_w0", 32'(cfgErr), 32'd1);
        checkOutput("run_valid_w0", 32'(outValid), 32'd1);
        applyCfg(4, 0, 8'h77, 0, 0);
        checkOutput("run_err_o0", 32'(cfgErr), 32'd1);
        checkOutput("run_sum_o0", 32'(sumSel), 32'h1F);

        // Reconfigure from RUN: width 8, then width 4 with a simultaneous frac write.
        applyCfg(8, 2, 8'h33, 0, 0);
        waitRise(1'b1, 100, k);
        applyCfg(4, 2, 8'h44, 1, 8'hAB);
        checkOutput("w4_valid_drop", 32'(outValid), 32'd0);
        checkOutput("w4_rstn_low",   32'(modRstN),  32'd0);
        waitRise(1'b0, 100, k);
        checkOutput("w4_rstn_lat", 32'(k), 32'd5);
        checkOutput("w4_efm", 32'(efmData), 32'h0B);
        waitRise(1'b1, 100, k);
        checkOutput("w4_valid_lat", 32'(k), 32'd16);

        // Request held across a busy window is accepted once ready returns.
        applyCfg(2, 1, 8'h01, 0, 0);
        applyStimulus(1'b1, 7, 2, 8'hC3, 0, 0);
        k = 0;
        while (cfgReady !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        cfgValid = 1'b0;
        checkOutput("held_sum", 32'(sumSel), 32'h7F);
        checkOutput("held_seed", 32'(seed), 32'hC3);
        waitRise(1'b1, 100, k);

        // Asynchronous reset during FILL.
        applyCfg(6, 2, 8'h99, 0, 0);
        waitRise(1'b0, 100, k);
        repeat (3) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(cfgReady), 32'd1);
        checkOutput("rst_busy",  32'(busy),     32'd0);
        checkOutput("rst_rstn",  32'(modRstN),  32'd0);
        checkOutput("rst_cout",  32'(coutSel),  32'h001);
        checkOutput("rst_sum",   32'(sumSel),   32'h00);
        checkOutput("rst_seed",  32'(seed),     32'h00);
        checkOutput("rst_stage", 32'(stageEn),  32'h0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_ready", 32'(cfgReady), 32'd1);
        checkOutput("post_rst_efm",   32'(efmData),  32'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 700; i++) begin
            applyStimulus(($urandom_range(0, 11) == 0), $urandom_range(0, 9),
                          $urandom_range(0, 3), $urandom_range(0, 255),
                          ($urandom_range(0, 3) == 0), $urandom_range(0, 255));
        end
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 0);
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
